// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multi-cycle multiply/divide sequencer holding the HI/LO registers.
// Sits beside the ALU in E. The 64-bit result is computed in a single cycle and
// parked in temp regs. A down-counter then holds busy for the target machine's
// latency, and the result is committed to HI/LO when the count expires.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, md_op_e    E-stage strobe and op (1 mult, 2 multu, 3 div, 4 divu,
//                     5 mthi, 6 mtlo, 7 mfhi, 8 mflo, others none)
//   src_a, src_b      forwarded rs/rt values in E
//   md_instr_d        stage D holds an MD-class instruction
//   md_out            HI (op 7) or LO (op 8) read port, else 0
//   hi, lo            architectural HI/LO registers
//   busy              mult/div in flight
//   md_stall          stall request to the hazard unit
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  md_op_e,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        md_instr_d,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        md_stall
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] temp_hi_q, temp_hi_d, temp_lo_q, temp_lo_d;
  logic        dz_q, dz_d;  // pending result came from a divide by zero
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  // ---- datapath ----
  logic [63:0] prod_s, prod_u;
  logic [31:0] divisor, mag_a, mag_b, uq, ur, sq, sr, dq, dr;
  logic        md_start;

  always_comb begin
    // Low 64 bits of the sign-extended product equal the signed product.
    prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    prod_u = {32'd0, src_a} * {32'd0, src_b};
    // Divisor forced to 1 on zero so the datapath never produces X; the
    // result is discarded anyway via dz.
    divisor = (src_b == 32'd0) ? 32'd1 : src_b;
    mag_a   = src_a[31] ? (32'd0 - src_a) : src_a;
    mag_b   = divisor[31] ? (32'd0 - divisor) : divisor;
    uq      = mag_a / mag_b;
    ur      = mag_a % mag_b;
    // Quotient negative when signs differ; remainder takes the dividend's sign.
    sq      = (src_a[31] ^ divisor[31]) ? (32'd0 - uq) : uq;
    sr      = src_a[31] ? (32'd0 - ur) : ur;
    dq      = src_a / divisor;
    dr      = src_a % divisor;
    md_start = start && (md_op_e >= OP_MULT) && (md_op_e <= OP_DIVU);
  end

  // ---- next state ----
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op_e)
            OP_MULT:  {temp_hi_d, temp_lo_d} = prod_s;
            OP_MULTU: {temp_hi_d, temp_lo_d} = prod_u;
            OP_DIV:   {temp_hi_d, temp_lo_d} = {sr, sq};
            OP_DIVU:  {temp_hi_d, temp_lo_d} = {dr, dq};
            OP_MTHI:  hi_d = src_a;
            OP_MTLO:  lo_d = src_a;
            default: ;
          endcase
          if (md_start) begin
            state_d = S_BUSY;
            dz_d    = (md_op_e == OP_DIV || md_op_e == OP_DIVU) && (src_b == 32'd0);
            cnt_d   = (md_op_e == OP_MULT || md_op_e == OP_MULTU) ?
                      4'(MULT_CYCLES) : 4'(DIV_CYCLES);
          end
        end
      end
      default: begin
        // start is ignored here; the hazard unit keeps it from happening.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          if (!dz_q) begin
            hi_d = temp_hi_q;
            lo_d = temp_lo_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      temp_hi_q <= 32'd0;
      temp_lo_q <= 32'd0;
      dz_q      <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // ---- outputs ----
  always_comb begin
    hi       = hi_q;
    lo       = lo_q;
    busy     = (state_q == S_BUSY);
    md_stall = md_instr_d && (busy || md_start);
    md_out   = 32'd0;
    if (md_op_e == OP_MFHI)      md_out = hi_q;
    else if (md_op_e == OP_MFLO) md_out = lo_q;
  end
endmodule

// File: tb/tb_md_unit_ctrl.sv
module tb_md_unit_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  md_op_e = 4'd0;
  logic [31:0] src_a = 32'd0, src_b = 32'd0;
  logic        md_instr_d = 1'b0;
  logic [31:0] md_out, hi, lo;
  logic        busy, md_stall;

  int errors = 0;
  int checks = 0;

  md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .start(start), .md_op_e(md_op_e),
    .src_a(src_a), .src_b(src_b), .md_instr_d(md_instr_d),
    .md_out(md_out), .hi(hi), .lo(lo), .busy(busy), .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model: edge-indexed completion time ----
  longint cyc = 0;      // number of clock edges seen
  longint done_at = 0;  // edge at which the pending result lands
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  logic p_dz = 0;

  function automatic logic [63:0] model_result(input logic [3:0] op,
                                               input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: return 64'(sa * sb);
      4'd2: return 64'(ua * ub);
      4'd3: return (b == 0) ? 64'd0 : {32'(sa % sb), 32'(sa / sb)};
      4'd4: return (b == 0) ? 64'd0 : {32'(ua % ub), 32'(ua / ub)};
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi <= 0; m_lo <= 0; done_at <= 0; p_dz <= 0; p_hi <= 0; p_lo <= 0;
    end else begin
      cyc <= cyc + 1;
      if (cyc + 1 == done_at && !p_dz) begin
        m_hi <= p_hi; m_lo <= p_lo;
      end
      if (!(cyc < done_at) && start) begin
        if (md_op_e >= 1 && md_op_e <= 4) begin
          {p_hi, p_lo} <= model_result(md_op_e, src_a, src_b);
          p_dz    <= (md_op_e >= 3) && (src_b == 0);
          done_at <= cyc + 1 + ((md_op_e <= 2) ? MC : DC);
        end else if (md_op_e == 5) m_hi <= src_a;
        else if (md_op_e == 6) m_lo <= src_a;
      end
    end
  end

  // ---- compare process ----
  always @(negedge clk) begin
    logic m_busy;
    logic [31:0] m_out;
    m_busy = (cyc < done_at);
    m_out  = (md_op_e == 7) ? m_hi : (md_op_e == 8) ? m_lo : 32'd0;
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("md_out", md_out, m_out);
    chk("md_stall", {31'd0, md_stall},
        {31'd0, md_instr_d & (m_busy | (start & md_op_e >= 1 & md_op_e <= 4))});
    if (busy && start && md_op_e >= 1 && md_op_e <= 6) begin
      errors++;
      $display("FAIL start_while_busy: op %0d issued while busy", md_op_e);
    end
  end

  // stall-cycle counter for the stall window test
  logic cnt_en = 0;
  int   stall_cnt = 0;
  always @(negedge clk) if (cnt_en && md_stall) stall_cnt <= stall_cnt + 1;

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1; md_op_e = op; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 0; md_op_e = 0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: busy still 1 expected 0", name);
    end
  endtask

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(posedge clk); #1 rst = 0;

    // 1. signed mult -2 * 3
    do_op(4'd1, 32'hFFFFFFFE, 32'd3);
    wait_idle("mult");
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);

    // 2. multu max * max
    do_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle("multu");
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);

    // 3. divides
    do_op(4'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle("div");
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    do_op(4'd4, 32'd7, 32'd2);
    wait_idle("divu");
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    do_op(4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("div_ovf");
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'd0);

    // 4. divide by zero keeps preloaded HI/LO
    do_op(4'd5, 32'h11, 32'd0);
    do_op(4'd6, 32'h22, 32'd0);
    do_op(4'd3, 32'd9, 32'd0);
    wait_idle("div0");
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);
    @(posedge clk); #1 start = 1; md_op_e = 4'd7;
    @(negedge clk); chk("mfhi", md_out, 32'h11);
    @(posedge clk); #1 md_op_e = 4'd8;
    @(negedge clk); chk("mflo", md_out, 32'h22);
    @(posedge clk); #1 start = 0; md_op_e = 0;

    // 5. stall window: 1 start cycle + DC busy cycles
    @(posedge clk); #1;
    stall_cnt = 0; cnt_en = 1; md_instr_d = 1;
    start = 1; md_op_e = 4'd4; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1 start = 0; md_op_e = 0;
    wait_idle("stall");
    @(negedge clk);
    cnt_en = 0; md_instr_d = 0;
    chk("stall_cycles", 32'(stall_cnt), 32'd11);
    chk("divu2_lo", lo, 32'd14);
    stall_cnt = 0; cnt_en = 1;
    do_op(4'd3, 32'd100, 32'd7);
    wait_idle("nostall");
    cnt_en = 0;
    chk("nostall_cycles", 32'(stall_cnt), 32'd0);

    // 6. async reset mid-mult
    do_op(4'd1, 32'd6, 32'd7);
    repeat (2) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(posedge clk); #1 rst = 0;
    do_op(4'd5, 32'd5, 32'd0);
    chk("post_rst_hi", hi, 32'd5);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    repeat (12) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
